// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Purpose  : Shared types, default constants and helpers for the LED digit
//            scan controller.
// Contents : nibble_t        - one hex digit
//            onehot_digit()  - bit n of the one-hot code for digit index idx
//            LED_*           - default parameter values
// Revision : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef logic [3:0] nibble_t;

    localparam int LED_NUM_DIGITS   = 8;
    localparam int LED_SCAN_DIV     = 50000;
    localparam int LED_BLANK_CYCLES = 16;

    // Returns bit n of one-hot(idx); called once per digit position so the
    // result width always matches the digit count of the caller.
    function automatic logic onehot_digit(input int unsigned idx, input int unsigned n);
        return (idx == n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_scan_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_prescaler
// Purpose  : Digit-slot timer. Counts 0..SCAN_DIV-1 and wraps; flags the last
//            cycle of each slot and the anti-ghosting blank window at the
//            start of each slot.
// Ports    : clk      in   system clock
//            rst      in   asynchronous active-high reset
//            slot_end out  high on the last cycle of a digit slot
//            blank    out  high while div_cnt < BLANK_CYCLES (BLANK state)
// Revision : 1.0 - initial release
// ============================================================================
module led_scan_prescaler
    import led_pkg::*;
#(
    parameter int SCAN_DIV     = LED_SCAN_DIV,
    parameter int BLANK_CYCLES = LED_BLANK_CYCLES
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end,
    output logic blank
);

    localparam int            CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    assign slot_end = (div_cnt_q == C_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + CW'(1);
        if (slot_end) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // A zero-length blank window is a constant, not a comparison.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = (div_cnt_q < CW'(BLANK_CYCLES));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/led_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_driver
// Purpose  : Time-multiplexed scan controller feeding a single hex-to-7-seg
//            decoder. Steps through NUM_DIGITS nibbles, presenting each on
//            hex_out with a one-hot digit enable. Value writes are double
//            buffered and committed only at frame boundaries.
// Ports    : clk        in   system clock
//            rst        in   asynchronous active-high reset
//            load       in   capture value_in into the pending buffer
//            value_in   in   new display value, digit 0 = bits [3:0]
//            pending    out  pending buffer holds an uncommitted value
//            hex_out    out  nibble of the current digit
//            digit_en   out  one-hot digit select, zero while blanking
//            frame_done out  one-cycle pulse after the last slot of a frame
// Options  : LED_SCAN_LEADING_ZERO_BLANK_EN - darken digits above the most
//            significant nonzero nibble (digit 0 always shown).
// Revision : 1.0 - initial release
// ============================================================================
module led_scan_driver
    import led_pkg::*;
#(
    parameter int NUM_DIGITS   = LED_NUM_DIGITS,
    parameter int SCAN_DIV     = LED_SCAN_DIV,
    parameter int BLANK_CYCLES = LED_BLANK_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    output logic                    pending,
    output nibble_t                 hex_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int            IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] C_LAST_IDX = IW'(NUM_DIGITS - 1);

    logic slot_end;
    logic blank;
    logic frame_end;
    logic commit;

    logic [IW-1:0]           idx_q,        idx_d;
    logic [4*NUM_DIGITS-1:0] active_q,     active_d;
    logic [4*NUM_DIGITS-1:0] pend_q,       pend_d;
    logic                    pending_q,    pending_d;
    nibble_t                 hex_out_q,    hex_out_d;
    logic [NUM_DIGITS-1:0]   digit_en_q,   digit_en_d;
    logic                    frame_done_q, frame_done_d;
`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0]   lz_mask_q,    lz_mask_d;
    logic                    lz_seen;
`endif

    led_scan_prescaler #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .slot_end (slot_end),
        .blank    (blank)
    );

    assign frame_end = slot_end && (idx_q == C_LAST_IDX);
    assign commit    = frame_end && (load || pending_q);

    always_comb begin
        idx_d        = idx_q;
        active_d     = active_q;
        pend_d       = pend_q;
        pending_d    = pending_q;
        hex_out_d    = '0;
        digit_en_d   = '0;
        frame_done_d = frame_end;

        // Explicit wrap so non-power-of-two digit counts work.
        if (slot_end) begin
            idx_d = (idx_q == C_LAST_IDX) ? '0 : idx_q + IW'(1);
        end

        // A load landing on the frame boundary bypasses the pending buffer.
        if (frame_end) begin
            if (load) begin
                active_d = value_in;
            end else if (pending_q) begin
                active_d = pend_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pend_d    = value_in;
            pending_d = 1'b1;
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                hex_out_d = active_q[4*i +: 4];
            end
        end

        if (!blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_en_d[i] = onehot_digit(32'(idx_q), i);
            end
        end

`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
        digit_en_d = digit_en_d & lz_mask_q;

        // Mask is recomputed only when a new value is committed; scanning
        // from the top, a digit stays lit once any nibble at or above it is
        // nonzero.
        lz_mask_d = lz_mask_q;
        lz_seen   = 1'b0;
        if (commit) begin
            for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                lz_seen      = lz_seen | (active_d[4*i +: 4] != 4'd0);
                lz_mask_d[i] = lz_seen | (i == 0);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pending_q    <= 1'b0;
            hex_out_q    <= '0;
            digit_en_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pending_q    <= pending_d;
            hex_out_q    <= hex_out_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
    // Reset value matches an all-zero active value: digit 0 only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lz_mask_q <= NUM_DIGITS'(1);
        end else begin
            lz_mask_q <= lz_mask_d;
        end
    end
`endif

    assign pending    = pending_q;
    assign hex_out    = hex_out_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_scan_driver
// Purpose  : Self-checking bench for led_scan_driver (4 digits, 8-cycle slots,
//            2 blank cycles). A frame-position reference model queues the
//            expected outputs each cycle; a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = N * DIV;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          load     = 1'b0;
    logic [15:0]   value_in = '0;
    logic          pending;
    logic [3:0]    hex_out;
    logic [N-1:0]  digit_en;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]   hex;
        logic [N-1:0] en;
        logic         fd;
        logic         pnd;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_exp;
    exp_t mon_e;

    // Reference model state: cycles since reset release, displayed value,
    // pending buffer.
    int          cyc;
    logic [15:0] shown;
    logic [15:0] pend_v;
    logic        pend_f;
    int          m_pos, m_slot, m_off;
    logic        m_fe;

    led_scan_driver #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value_in   (value_in),
        .pending    (pending),
        .hex_out    (hex_out),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, req, $time);
        end
    endtask

    // Digits that may light for a given displayed value.
    function automatic logic [N-1:0] vis_mask(input logic [15:0] v);
        logic [N-1:0] m;
`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
        int top;
        top = 0;
        for (int d = 0; d < N; d++) begin
            if (v[4*d +: 4] != 4'd0) top = d;
        end
        m = '0;
        for (int d = 0; d < N; d++) begin
            if (d <= top) m[d] = 1'b1;
        end
`else
        m = (v == 16'hFFFF) ? '1 : '1;
`endif
        return m;
    endfunction

    // Reference model: outputs after each edge are derived from the frame
    // position of the state being left.
    always @(posedge clk) begin
        if (rst) begin
            cyc    = 0;
            shown  = '0;
            pend_v = '0;
            pend_f = 1'b0;
        end else begin
            m_pos  = cyc % FRAME;
            m_slot = m_pos / DIV;
            m_off  = m_pos % DIV;
            m_fe   = (m_pos == FRAME - 1);
            m_exp.hex = shown[4*m_slot +: 4];
            m_exp.en  = (m_off >= BLK) ? ((N'(1) << m_slot) & vis_mask(shown)) : '0;
            m_exp.fd  = m_fe;
            if (m_fe) begin
                if (load)        shown = value_in;
                else if (pend_f) shown = pend_v;
                pend_f = 1'b0;
            end else if (load) begin
                pend_v = value_in;
                pend_f = 1'b1;
            end
            m_exp.pnd = pend_f;
            exp_q.push_back(m_exp);
            cyc++;
        end
    end

    // Monitor: compares DUT outputs on the falling edge.
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("hex_out",    32'(hex_out),    32'(mon_e.hex));
            chk("digit_en",   32'(digit_en),   32'(mon_e.en));
            chk("frame_done", 32'(frame_done), 32'(mon_e.fd));
            chk("pending",    32'(pending),    32'(mon_e.pnd));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        if (n > 0) #1;
    endtask

    // Advance until the DUT's current frame position equals target.
    task automatic goto_pos(input int target);
        for (int k = 0; k <= FRAME; k++) begin
            @(posedge clk);
            #1;
            if (cyc % FRAME == target) return;
        end
        checks++;
        errors++;
        $display("FAIL goto_pos: frame position %0d not reached", target);
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        value_in = v;
        @(posedge clk);
        #1;
        load     = 1'b0;
        value_in = 16'($urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;

        #1 rst = 1'b1;
        #2;
        chk("rst_hex_out",    32'(hex_out),    32'h0);
        chk("rst_digit_en",   32'(digit_en),   32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_pending",    32'(pending),    32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Idle scanning of an all-zero value.
        wait_cycles(2 * FRAME);

        // Mid-frame load held until the boundary.
        goto_pos(10);
        do_load(16'hA3C5);
        wait_cycles(2 * FRAME);

        // Last write within a frame wins.
        goto_pos(5);
        do_load(16'h1111);
        goto_pos(15);
        do_load(16'h2222);
        wait_cycles(2 * FRAME);

        // Load coinciding with the frame boundary bypasses the buffer.
        goto_pos(FRAME - 1);
        do_load(16'h0F0F);
        wait_cycles(2 * FRAME);

        // Leading-zero patterns.
        goto_pos(3);
        do_load(16'h0040);
        wait_cycles(2 * FRAME);
        goto_pos(3);
        do_load(16'h0000);
        wait_cycles(2 * FRAME);

        // Randomised loads, including boundary hits and leading zeros.
        for (int i = 0; i < 40; i++) begin
            wait_cycles($urandom_range(0, 40));
            v = 16'($urandom);
            case ($urandom_range(0, 4))
                0:       v = v & 16'h00FF;
                1:       v = v & 16'h000F;
                2:       v = 16'h0000;
                default: v = v;
            endcase
            do_load(v);
        end
        wait_cycles(2 * FRAME);

        // Asynchronous reset mid-frame at digit 2, prescaler count 5.
        do_load(16'h9876);
        wait_cycles(2 * FRAME);
        goto_pos(2 * DIV + 5);
        chk("pre_rst_digit_en", 32'(digit_en), 32'(4'b0100));
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_hex_out",    32'(hex_out),    32'h0);
        chk("async_rst_digit_en",   32'(digit_en),   32'h0);
        chk("async_rst_frame_done", 32'(frame_done), 32'h0);
        chk("async_rst_pending",    32'(pending),    32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(2 * FRAME);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
